// File: rtl/riscv_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM state encoding,
// default frame marker and word size.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_e;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned WORD_BYTES        = 4;

endpackage

// File: rtl/byte_word_assembler.sv
// Little-endian byte-to-word shift register; word_valid_o pulses the cycle
// after the fourth byte of a word has been taken.
module byte_word_assembler
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;

    always_comb begin
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clear_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (byte_valid_i) begin
            // Shifting in from the top lands the first byte in [7:0] after four bytes.
            word_d  = {byte_i, word_q[31:8]};
            cnt_d   = cnt_q + 2'd1;
            valid_d = (cnt_q == 2'(WORD_BYTES - 1));
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: parses A5/len_lo/len_hi/data frames from the UART, writes words to
// instruction memory and releases the core. INSTRUCTION_LOADER_CHECKSUM_EN adds an XOR check byte.
module instruction_loader
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_data_o,
    output logic        core_reset_o,
    output logic        busy_o,
    output logic        error_o
);

    localparam int unsigned IDX_W     = ADDR_WIDTH + 1;
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

    loader_state_e    state_q, state_d;
    logic [15:0]      length_q, length_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;

    logic        sync_hit;
    logic        asm_byte_valid;
    logic [31:0] asm_word;
    logic        asm_word_valid;
    logic [15:0] length_new;

    assign sync_hit       = (state_q == ST_IDLE) && rx_valid_i && (rx_data_i == SYNC_BYTE);
    assign asm_byte_valid = (state_q == ST_DATA) && rx_valid_i;
    assign length_new     = {rx_data_i, length_q[7:0]};

    byte_word_assembler u_asm (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (sync_hit),
        .byte_valid_i (asm_byte_valid),
        .byte_i       (rx_data_i),
        .word_o       (asm_word),
        .word_valid_o (asm_word_valid)
    );

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    localparam loader_state_e ST_AFTER_DATA = ST_CHK;

    logic [7:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (sync_hit) begin
            chk_d = '0;
        end else if (asm_byte_valid) begin
            chk_d = chk_q ^ rx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`else
    localparam loader_state_e ST_AFTER_DATA = ST_DONE;
`endif

    always_comb begin
        state_d    = state_q;
        length_d   = length_q;
        word_idx_d = word_idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sync_hit) begin
                    state_d    = ST_LEN_LO;
                    length_d   = '0;
                    word_idx_d = '0;
                end
            end
            ST_LEN_LO: begin
                if (rx_valid_i) begin
                    length_d[7:0] = rx_data_i;
                    state_d       = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid_i) begin
                    length_d[15:8] = rx_data_i;
                    if (length_new == 16'd0) begin
                        state_d = ST_AFTER_DATA;
                    end else if (32'(length_new) > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // The write pulse marks a completed word; advance the index as it retires.
                if (asm_word_valid) begin
                    word_idx_d = word_idx_q + IDX_W'(1);
                    if (32'(word_idx_q) + 32'd1 == 32'(length_q)) begin
                        state_d = ST_AFTER_DATA;
                    end
                end
            end
            ST_CHK: begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                if (rx_valid_i) begin
                    state_d = (rx_data_i == chk_q) ? ST_DONE : ST_ERROR;
                end
`else
                state_d = ST_ERROR;
`endif
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            length_q   <= '0;
            word_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            length_q   <= length_d;
            word_idx_q <= word_idx_d;
        end
    end

    assign imem_we_o    = asm_word_valid;
    assign imem_data_o  = asm_word;
    assign imem_addr_o  = IMEM_BASE + (32'(word_idx_q) << 2);
    assign core_reset_o = (state_q == ST_DONE);
    assign error_o      = (state_q == ST_ERROR);
    assign busy_o       = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                          (state_q == ST_DATA)   || (state_q == ST_CHK);

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: two instances (base 0 and base 0x100)
// share the byte stream; expected writes are queued and checked by monitors.
module tb_instruction_loader;

    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;

    logic        we_a, we_b;
    logic [31:0] addr_a, addr_b, data_a, data_b;
    logic        core_rst_a, core_rst_b, busy_a, busy_b, err_a, err_b;

    int asserts = 0;
    int fails   = 0;

    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];
    logic [31:0] frame_w[$];

    always #5 clk = ~clk;

    instruction_loader #(.ADDR_WIDTH(10), .SYNC_BYTE(8'hA5), .IMEM_BASE(BASE_A)) dut_a (
        .clk_i(clk), .reset_i(reset_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .imem_we_o(we_a), .imem_addr_o(addr_a), .imem_data_o(data_a),
        .core_reset_o(core_rst_a), .busy_o(busy_a), .error_o(err_a)
    );

    instruction_loader #(.ADDR_WIDTH(10), .SYNC_BYTE(8'hA5), .IMEM_BASE(BASE_B)) dut_b (
        .clk_i(clk), .reset_i(reset_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .imem_we_o(we_b), .imem_addr_o(addr_b), .imem_data_o(data_b),
        .core_reset_o(core_rst_b), .busy_o(busy_b), .error_o(err_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Write monitors: every pulse must match the head of its scoreboard queue.
    always @(negedge clk) begin
        if (we_a) begin
            if (exp_a.size() == 0) begin
                asserts++; fails++;
                $display("FAIL unexpected_write_a actual=%h/%h required=no_write", addr_a, data_a);
            end else begin
                chk("write_a", {addr_a, data_a}, exp_a.pop_front());
            end
        end
        if (we_b) begin
            if (exp_b.size() == 0) begin
                asserts++; fails++;
                $display("FAIL unexpected_write_b actual=%h/%h required=no_write", addr_b, data_b);
            end else begin
                chk("write_b", {addr_b, data_b}, exp_b.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Queues the expected writes for frame_w and sends a complete frame.
    task automatic send_frame(input logic [7:0] chk_adj);
        logic [7:0]  x;
        logic [31:0] w;
        logic [15:0] n;
        x = 8'h00;
        n = 16'(frame_w.size());
        for (int i = 0; i < frame_w.size(); i++) begin
            exp_a.push_back({BASE_A + 32'(4 * i), frame_w[i]});
            exp_b.push_back({BASE_B + 32'(4 * i), frame_w[i]});
        end
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < frame_w.size(); i++) begin
            w = frame_w[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[7:0]);
                x = x ^ w[7:0];
                w = w >> 8;
            end
        end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        send_byte(x + chk_adj);
`else
        x = x + chk_adj;
`endif
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_we"},    {62'd0, we_a, we_b},            64'd0);
        chk({tag, "_addr"},  {addr_a, addr_b},               {BASE_A, BASE_B});
        chk({tag, "_data"},  {data_a, data_b},               64'd0);
        chk({tag, "_flags"}, {58'd0, core_rst_a, core_rst_b, busy_a, busy_b, err_a, err_b}, 64'd0);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_flags"}, {58'd0, core_rst_a, core_rst_b, busy_a, busy_b, err_a, err_b},
            64'b110000);
        chk({tag, "_pending"}, 64'(exp_a.size() + exp_b.size()), 64'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random traffic.
        reset_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            rx_data  = 8'($urandom);
            rx_valid = 1'($urandom);
            @(negedge clk);
            if (i % 4 == 3) chk_idle_outputs("reset_hold");
        end
        rx_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk_idle_outputs("reset_release");

        // Single word 0x00500013 with explicit write/release timing.
        exp_a.push_back({BASE_A, 32'h0050_0013});
        exp_b.push_back({BASE_B, 32'h0050_0013});
        send_byte(8'hA5);
        chk("single_busy", {62'd0, busy_a, busy_b}, 64'b11);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h50);
        rx_data = 8'h00; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        chk("single_pulse", {62'd0, we_a, core_rst_a}, 64'b10);
        @(posedge clk); #1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        chk("single_after", {62'd0, we_a, core_rst_a}, 64'b00);
        repeat (3) @(posedge clk);
        #1;
        send_byte(8'h43);
`else
        chk("single_after", {62'd0, we_a, core_rst_a}, 64'b01);
        repeat (3) @(posedge clk);
        #1;
`endif
        chk_done("single_done");

        // Three words, then post-DONE traffic must not write.
        do_reset();
        frame_w = '{32'h1122_3344, 32'hDEAD_BEEF, 32'h0000_00A5};
        send_frame(8'h00);
        chk_done("three_done");
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'h77);
        chk_done("three_post");

        // Leading garbage before sync.
        do_reset();
        send_byte(8'h00); send_byte(8'hFF);
        chk("garbage_idle", {62'd0, busy_a, busy_b}, 64'b00);
        frame_w = '{32'hCAFE_F00D};
        send_frame(8'h00);
        chk_done("garbage_done");

        // Length 0x0401 exceeds 1024 words.
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
        for (int i = 0; i < 4; i++) send_byte(8'h5A);
        chk("len_err_flags", {58'd0, core_rst_a, core_rst_b, busy_a, busy_b, err_a, err_b},
            64'b000011);

        // Length 0x0400 fills memory exactly and is accepted.
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
        chk("len_max_flags", {58'd0, core_rst_a, core_rst_b, busy_a, busy_b, err_a, err_b},
            64'b001100);

        // Length zero.
        do_reset();
        frame_w = {};
        send_frame(8'h00);
        chk_done("len0_done");

        // Reset after 6 of 12 data bytes, then a full resend.
        do_reset();
        exp_a.push_back({BASE_A, 32'h0403_0201});
        exp_b.push_back({BASE_B, 32'h0403_0201});
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        reset_n = 1'b0;
        #2;
        chk_idle_outputs("abort");
        chk("abort_pending", 64'(exp_a.size() + exp_b.size()), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        frame_w = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09};
        send_frame(8'h00);
        chk_done("resend_done");

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        // Bad checksum 0x44: write happens, load fails.
        do_reset();
        frame_w = '{32'h0050_0013};
        send_frame(8'h01);
        chk("bad_chk_flags", {58'd0, core_rst_a, core_rst_b, busy_a, busy_b, err_a, err_b},
            64'b000011);
        chk("bad_chk_pending", 64'(exp_a.size() + exp_b.size()), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
